// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, the zero-register index and a popcount helper
// for the register file and its pending-write scoreboard.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;
    localparam int POP_MAX_W  = 256;

    // Number of set bits in a busy vector (zero-extended to POP_MAX_W).
    function automatic int popcount(input logic [POP_MAX_W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits, issue handshake
// and a registered count of pending registers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic                 issue_valid,
    input  logic [ADDR_W-1:0]    issue_addr,
    input  logic                 flush,
    output logic                 issue_ready,
    output logic [2**ADDR_W-1:0] busy,
    output logic [ADDR_W:0]      busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [ADDR_W:0]  r_cnt;
    logic [ADDR_W:0]  w_cnt_nxt;
    logic             w_wr_nz;
    logic             w_iss_nz;
    logic             w_same;
    logic             w_fire;
    logic             w_inc;
    logic             w_dec;

    assign w_wr_nz  = we && (waddr != ZADDR);
    assign w_iss_nz = issue_addr != ZADDR;
    assign w_same   = w_wr_nz && (waddr == issue_addr);

    // A same-cycle write to the destination lets a WAW issue through.
    assign issue_ready = !w_iss_nz || !r_busy[issue_addr] || w_same;
    assign w_fire      = issue_valid && issue_ready && !flush && w_iss_nz;

    assign w_inc = w_fire && !r_busy[issue_addr];
    assign w_dec = w_wr_nz && r_busy[waddr] && !(w_fire && w_same);

    // Next busy/count: flush wins, then issue-set over write-clear.
    always_comb begin
        w_busy_nxt = r_busy;
        w_cnt_nxt  = r_cnt;
        if (flush) begin
            w_busy_nxt = '0;
            w_cnt_nxt  = '0;
        end else begin
            if (w_wr_nz) begin
                w_busy_nxt[waddr] = 1'b0;
            end
            if (w_fire) begin
                w_busy_nxt[issue_addr] = 1'b1;
            end
            w_cnt_nxt = r_cnt + {{ADDR_W{1'b0}}, w_inc}
                              - {{ADDR_W{1'b0}}, w_dec};
        end
    end

    // Busy bits and count update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign busy     = r_busy;
    assign busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: register file with NUM_RD combinational read ports,
// optional write-to-read bypass and a pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     issue_ready,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  w_busy;
    logic              w_wr_nz;
    logic              w_byp_en;
    logic [ADDR_W-1:0] w_ra;
    logic              w_hit;

    assign w_wr_nz  = we && (waddr != ZADDR);
    // Forwarding is held off during reset so outputs read as zero.
    assign w_byp_en = (BYPASS != 0) && rst_n && w_wr_nz;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_sb (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (we),
        .waddr       (waddr),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .flush       (flush),
        .issue_ready (issue_ready),
        .busy        (w_busy),
        .busy_cnt    (busy_cnt)
    );

    // Storage; r0 is never written so it always holds zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_wr_nz) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read ports with optional same-cycle forwarding and busy masking.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        w_ra    = '0;
        w_hit   = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_ra  = rd_addr[i*ADDR_W +: ADDR_W];
            w_hit = w_byp_en && (waddr == w_ra);
            rd_data[i*DATA_W +: DATA_W] = w_hit ? wdata : r_mem[w_ra];
            rd_busy[i] = w_busy[w_ra] && !w_hit;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed checks of regfile_sb with forwarding (4 ports)
// and without forwarding (2 ports) sharing the write/issue stimulus.
module tb_regfile_sb;

    logic         clk;
    logic         rst_n;
    logic         we;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic         issue_valid;
    logic [4:0]   issue_addr;
    logic         flush;

    logic [19:0]  rd_addr_a;
    logic [127:0] rd_data_a;
    logic [3:0]   rd_busy_a;
    logic         issue_ready_a;
    logic [5:0]   busy_cnt_a;

    logic [9:0]   rd_addr_b;
    logic [63:0]  rd_data_b;
    logic [1:0]   rd_busy_b;
    logic         issue_ready_b;
    logic [5:0]   busy_cnt_b;

    int total;
    int bad;

    regfile_sb #(
        .DATA_W (32),
        .ADDR_W (5),
        .NUM_RD (4),
        .BYPASS (1)
    ) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr_a),
        .rd_data     (rd_data_a),
        .rd_busy     (rd_busy_a),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready_a),
        .flush       (flush),
        .busy_cnt    (busy_cnt_a)
    );

    regfile_sb #(
        .DATA_W (32),
        .ADDR_W (5),
        .NUM_RD (2),
        .BYPASS (0)
    ) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr_b),
        .rd_data     (rd_data_b),
        .rd_busy     (rd_busy_b),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready_b),
        .flush       (flush),
        .busy_cnt    (busy_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we          = 1'b0;
        issue_valid = 1'b0;
        flush       = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        we          = 1'b0;
        waddr       = '0;
        wdata       = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;
        flush       = 1'b0;
        rd_addr_a   = '0;
        rd_addr_b   = '0;
        step();
        step();
        chk("rst_data", rd_data_a, 128'h0);
        chk("rst_cnt", busy_cnt_a, 6'd0);
        chk("rst_ready", issue_ready_a, 1'b1);
        rst_n = 1'b1;
        step();

        // Build state, then reset asynchronously mid-cycle.
        we = 1'b1; waddr = 5'd5; wdata = 32'h1111;
        issue_valid = 1'b1; issue_addr = 5'd3;
        step();
        idle();
        rd_addr_a = {5'd0, 5'd0, 5'd3, 5'd5};
        #1;
        chk("pre_rst_r5", rd_data_a[31:0], 32'h1111);
        chk("pre_rst_cnt", busy_cnt_a, 6'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", rd_data_a, 128'h0);
        chk("mid_rst_cnt", busy_cnt_a, 6'd0);
        chk("mid_rst_busy", rd_busy_a, 4'b0000);
        step();
        rst_n = 1'b1;
        we = 1'b1; waddr = 5'd0; wdata = 32'hDEADBEEF;
        step();
        waddr = 5'd5;
        step();
        idle();
        rd_addr_a = {5'd0, 5'd0, 5'd5, 5'd0};
        #1;
        chk("r0_zero", rd_data_a[31:0], 32'h0);
        chk("r5_val", rd_data_a[63:32], 32'hDEADBEEF);
        chk("post_rst_cnt", busy_cnt_a, 6'd0);

        // Bypass vs. no bypass on r7.
        rd_addr_a = {5'd0, 5'd0, 5'd0, 5'd7};
        rd_addr_b = {5'd0, 5'd7};
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
        #1;
        chk("byp_on", rd_data_a[31:0], 32'h12345678);
        chk("byp_off_old", rd_data_b[31:0], 32'h0);
        step();
        idle();
        #1;
        chk("byp_off_new", rd_data_b[31:0], 32'h12345678);

        // Scoreboard handshake on r3.
        issue_valid = 1'b1; issue_addr = 5'd3;
        #1;
        chk("iss3_ready", issue_ready_a, 1'b1);
        step();
        idle();
        rd_addr_a = {5'd0, 5'd0, 5'd0, 5'd3};
        rd_addr_b = {5'd0, 5'd3};
        #1;
        chk("r3_busy", rd_busy_a[0], 1'b1);
        chk("r3_cnt", busy_cnt_a, 6'd1);
        issue_valid = 1'b1; issue_addr = 5'd3;
        #1;
        chk("waw_block", issue_ready_a, 1'b0);
        step();
        issue_valid = 1'b0;
        we = 1'b1; waddr = 5'd3; wdata = 32'hA5;
        #1;
        chk("waw_wr_ready", issue_ready_a, 1'b1);
        chk("waw_wr_ready_nb", issue_ready_b, 1'b1);
        chk("byp_busy_mask", rd_busy_a[0], 1'b0);
        chk("nobyp_busy", rd_busy_b[0], 1'b1);
        step();
        idle();
        #1;
        chk("r3_clr", rd_busy_a[0], 1'b0);
        chk("r3_clr_cnt", busy_cnt_a, 6'd0);
        chk("r3_data", rd_data_a[31:0], 32'hA5);

        // Simultaneous issue and write on pending r9.
        issue_valid = 1'b1; issue_addr = 5'd9;
        step();
        we = 1'b1; waddr = 5'd9; wdata = 32'hFF;
        step();
        idle();
        rd_addr_a = {5'd0, 5'd0, 5'd0, 5'd9};
        #1;
        chk("r9_data", rd_data_a[31:0], 32'hFF);
        chk("r9_busy", rd_busy_a[0], 1'b1);
        chk("r9_cnt", busy_cnt_a, 6'd1);
        we = 1'b1; waddr = 5'd9; wdata = 32'hFF;
        step();
        idle();

        // Flush together with an issue and a write.
        issue_valid = 1'b1; issue_addr = 5'd1;
        step();
        issue_addr = 5'd2;
        step();
        issue_addr = 5'd4;
        step();
        idle();
        #1;
        chk("fl_pre_cnt", busy_cnt_a, 6'd3);
        flush = 1'b1;
        issue_valid = 1'b1; issue_addr = 5'd6;
        we = 1'b1; waddr = 5'd2; wdata = 32'h55;
        step();
        idle();
        rd_addr_a = {5'd4, 5'd6, 5'd2, 5'd1};
        #1;
        chk("fl_cnt", busy_cnt_a, 6'd0);
        chk("fl_busy", rd_busy_a, 4'b0000);
        chk("fl_r2", rd_data_a[63:32], 32'h55);

        // Saturation: every non-zero register pending.
        for (int i = 1; i < 32; i++) begin
            issue_valid = 1'b1;
            issue_addr  = 5'(i);
            step();
        end
        issue_addr = 5'd0;
        #1;
        chk("sat_r0_ready", issue_ready_a, 1'b1);
        step();
        idle();
        rd_addr_a = {5'd31, 5'd20, 5'd10, 5'd1};
        issue_addr = 5'd10;
        #1;
        chk("sat_cnt", busy_cnt_a, 6'd31);
        chk("sat_cnt_b", busy_cnt_b, 6'd31);
        chk("sat_busy", rd_busy_a, 4'b1111);
        chk("sat_ready", issue_ready_a, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
